apb_master: RTL

- APB requester that drives the peripheral bus toward our APB responder blocks (8-bit address, 8-bit data).
- Accepts single read/write commands on a valid/ready command port.
- Sequences the command through the APB SETUP and ACCESS phases, honouring pready wait states.
- Returns read data (and optionally an error) on a one-cycle response strobe.
- Sits between an internal controller/CPU-side agent and the APB slave fabric.

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_master.sv | 138 +++++++++++++
 2 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB widths and requester state encoding
// Holds the default address/data widths used by the APB requester and the
// responder blocks on the same fabric, plus the requester FSM state type.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB requester: single read/write commands sequenced through SETUP/ACCESS
// Optional feature macro: APB_MASTER_TIMEOUT_EN (ACCESS wait-state timeout with error response).
// Ports:
//   pclk, presetn                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_write, cmd_addr, cmd_wdata   command fields (sampled only on accept)
//   rsp_valid                        one-cycle completion strobe
//   rsp_rdata                        read data of the last completed read (0 after an abort)
//   rsp_err                          completion was a timeout abort (0 unless the macro is defined)
//   paddr, pwdata, pwrite            APB address/data/direction, held from SETUP to end of ACCESS
//   pselx, penable                   APB select/enable
//   prdata, pready                   APB read data and wait-state control
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
`ifdef APB_MASTER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              pselx,
  output logic              penable,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  apb_state_t state;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_next;
  logic             err_q;

  assign wait_cnt_next = wait_cnt + CNT_W'(1);
  assign rsp_err       = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      pselx     <= 1'b0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pwrite    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      // Completion strobe and its error flag only live for one cycle.
      rsp_valid <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            paddr     <= cmd_addr;
            pwdata    <= cmd_wdata;
            pwrite    <= cmd_write;
            pselx     <= 1'b1;
            penable   <= 1'b0;
            cmd_ready <= 1'b0;
            state     <= SETUP;
          end
        end

        SETUP: begin
          penable  <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state    <= ACCESS;
        end

        ACCESS: begin
          if (pready) begin
            if (!pwrite) begin
              rsp_rdata <= prdata;
            end
            rsp_valid <= 1'b1;
            pselx     <= 1'b0;
            penable   <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          // The cycle that would bring the count to the limit is the last
          // one we wait; without pready there the transfer is abandoned.
          else if (wait_cnt_next == CNT_LIMIT) begin
            rsp_rdata <= '0;
            rsp_valid <= 1'b1;
            err_q     <= 1'b1;
            pselx     <= 1'b0;
            penable   <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt_next;
          end
`endif
        end

        default: begin
          pselx     <= 1'b0;
          penable   <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
